tr_fuzzify: RTL and testbench
=============================

# tr_fuzzify

Sequential interval type-2 fuzzifier for the trapezoidal fuzzy controller. It sits at the input end of the processing chain, ahead of the inference stage and the type-reduction/defuzzification block. It takes one crisp 8-bit sample and computes upper and lower membership grades for three trapezoidal sets. The six grades are presented together on FOU_k_UP/FOU_k_LOW, the same bus that the defuzzifier consumes downstream. A single shared iterative divider evaluates the grades one after another, and start/done handshaking frames each conversion.

## Interface
- H_UP, 8'd255: height of every upper MF (1.0).
- H_LOW, 8'd204: height of every lower MF (≈0.8).
- clk in 1: system clock. Single clock domain.
- rst in 1: reset, synchronous, active-high.
- EN_SCLK in 1: clock enable. When it is 0 the whole block freezes: state, counters, registers and outputs all hold.
- start in 1: request a conversion. Sampled only in IDLE with EN_SCLK=1.
- x in 8: crisp input. Captured on the cycle start is accepted.
- busy out 1: 1 from the cycle after start is accepted until done.
- done out 1: 1-cycle pulse when a new result set is visible on the outputs.
- FOU_1_UP, FOU_2_UP, FOU_3_UP out 8 each: upper grades for sets 1–3 (left shoulder, centre, right shoulder).
- FOU_1_LOW, FOU_2_LOW, FOU_3_LOW out 8 each: lower grades for sets 1–3.

## Operation
- States:
  - IDLE → LOAD on start.
  - LOAD: capture x; clear the evaluation index k.
  - For each k: CALC (1 cycle) → DIV (16 cycles) → WB (1 cycle).
  - After the last k, WB → DONE (1 cycle) → IDLE.
- Evaluation order for k: 1U, 2U, 3U, 1L, 2L, 3L.
- Each evaluation uses breakpoints a ≤ b ≤ c ≤ d and height H. Region checks in CALC, in priority order:
  - b ≤ x ≤ c → grade = H.
  - x ≤ a or x ≥ d → grade = 0.
  - a < x < b → grade = H·(x−a)/(b−a).
  - c < x < d → grade = H·(d−x)/(d−c).
- Shoulders are encoded as a=b=0 (left) or c=d=255 (right). Because the plateau check comes first, x=0 on set 1 and x=255 on set 3 both give H.
- A vertical edge (a=b or c=d) makes its slope region empty, so the divider never sees a zero divisor.
- Arithmetic:
  - Numerator is 16 bits (8×8 product); denominator is 8 bits.
  - Quotient is truncated. Any result above 255 is clamped to 255.
- Plateau and zero evaluations still spend the full 16 DIV cycles, so latency is fixed.
- WB writes the grade into a shadow register. DONE copies all six shadows to the outputs in one cycle and pulses done.
- start while busy is ignored. x changes while busy are ignored.
- rst at any time: go to IDLE; busy=0, done=0, all FOU outputs and shadows = 0.

## Timing
- Reset values: every output is 0.
- Latency: start accepted on enabled edge E0. done is high during the 110th enabled cycle after E0 (1 LOAD + 6×18 + 1 DONE cycles).
- Outputs change only on the DONE edge and hold until the next DONE or reset.
- EN_SCLK=0 stretches latency by exactly the number of disabled cycles. done stays high until the next enabled edge.
- start is accepted again in IDLE on the enabled cycle right after the DONE cycle. Back-to-back conversions are therefore spaced 111 enabled cycles apart.

## Configuration
- TR_FUZZY_LOWER_EN defined:
  - Lower MFs use their own breakpoints from the package.
  - All six evaluations run; latency is 110.
- TR_FUZZY_LOWER_EN undefined:
  - Only 1U, 2U and 3U are evaluated.
  - In WB, each lower shadow is set to (upper·H_LOW)>>8.
  - Latency is 1 + 3×18 + 1 = 56.

## Structure
- Package tr_fuzzy_pkg holds:
  - The FSM state enum.
  - The DIV iteration count (16).
  - Breakpoint constants:
    - 1U 0,0,64,128; 1L 0,0,48,112.
    - 2U 64,112,144,192; 2L 80,120,136,176.
    - 3U 128,192,255,255; 3L 144,208,255,255.
- Sub-module tr_fuzzy_div: restoring 16/8 unsigned divider, one bit per cycle. Ports: load, dividend, divisor, quotient, valid.

## Test plan
- Reset, then hold idle → all outputs 0, busy=0, done=0.
- x=0, start (macro on) → done at enabled cycle 110. FOU_1_UP=255, FOU_1_LOW=204; all other grades 0.
- x=96 (macro on) → UP = 127, 170, 0; LOW = 51, 81, 0.
- x=128 (macro on) → FOU_2_UP=255, FOU_2_LOW=204; all others 0. Repeat with the macro off → FOU_2_LOW=203, done at cycle 56.
- x=96 with EN_SCLK held low for 7 cycles mid-DIV → done at enabled cycle 110 (wall-clock cycle 117). Same grades as the x=96 case.
- Pulse start again at cycle 20 of a conversion → ignored, one done only. Assert rst at cycle 50 → outputs 0 and IDLE. A new start then gives correct results.

Source files
------------

// File: rtl/tr_fuzzy_pkg.sv
// Shared types and constants for the interval type-2 trapezoidal fuzzifier:
// FSM states, slope regions, divider length and the six MF breakpoint sets.
package tr_fuzzy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DIV,
    S_WB,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_PLAT,
    R_ZERO,
    R_RISE,
    R_FALL
  } region_t;

  localparam int DIV_ITERS = 16;

  localparam logic [7:0] H_UP  = 8'd255;
  localparam logic [7:0] H_LOW = 8'd204;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [7:0] h;
  } mf_t;

  // Index k follows evaluation order: 1U, 2U, 3U, 1L, 2L, 3L.
  function automatic mf_t mf_params(input logic [2:0] k);
    case (k)
      3'd0:    mf_params = '{a: 8'd0,   b: 8'd0,   c: 8'd64,  d: 8'd128, h: H_UP};
      3'd1:    mf_params = '{a: 8'd64,  b: 8'd112, c: 8'd144, d: 8'd192, h: H_UP};
      3'd2:    mf_params = '{a: 8'd128, b: 8'd192, c: 8'd255, d: 8'd255, h: H_UP};
      3'd3:    mf_params = '{a: 8'd0,   b: 8'd0,   c: 8'd48,  d: 8'd112, h: H_LOW};
      3'd4:    mf_params = '{a: 8'd80,  b: 8'd120, c: 8'd136, d: 8'd176, h: H_LOW};
      3'd5:    mf_params = '{a: 8'd144, b: 8'd208, c: 8'd255, d: 8'd255, h: H_LOW};
      default: mf_params = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd0,   h: 8'd0};
    endcase
  endfunction

endpackage

// File: rtl/tr_fuzzy_div.sv
// Restoring 16/8 unsigned divider, one quotient bit per enabled cycle.
// The first bit is resolved on the load edge, so valid rises after 16 enabled edges.
module tr_fuzzy_div
  import tr_fuzzy_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic        valid
);

  logic [7:0]  rem;
  logic [15:0] quo;
  logic [7:0]  dvsr;
  logic [3:0]  count;

  // Returns {next remainder, next quotient shift register}.
  function automatic logic [23:0] div_step(input logic [7:0] r, input logic [15:0] q,
                                           input logic [7:0] dv);
    logic [8:0] sh;
    logic       ge;
    sh = {r, q[15]};
    ge = (sh >= {1'b0, dv});
    div_step = {(ge ? 8'(sh - {1'b0, dv}) : sh[7:0]), q[14:0], ge};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      count <= '0;
    end else if (en) begin
      if (load) begin
        {rem, quo} <= div_step(8'd0, dividend, divisor);
        dvsr       <= divisor;
        count      <= 4'(DIV_ITERS - 1);
      end else if (count != 4'd0) begin
        {rem, quo} <= div_step(rem, quo, dvsr);
        count      <= count - 4'd1;
      end
    end
  end

  assign quotient = quo;
  assign valid    = (count == 4'd0);

endmodule

// File: rtl/tr_fuzzify.sv
// Sequential interval type-2 fuzzifier: one shared divider evaluates the trapezoid grades.
// Define TR_FUZZY_LOWER_EN to evaluate lower MFs separately instead of scaling the uppers.
module tr_fuzzify
  import tr_fuzzy_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       EN_SCLK,
  input  logic       start,
  input  logic [7:0] x,
  output logic       busy,
  output logic       done,
  output logic [7:0] FOU_1_UP,
  output logic [7:0] FOU_2_UP,
  output logic [7:0] FOU_3_UP,
  output logic [7:0] FOU_1_LOW,
  output logic [7:0] FOU_2_LOW,
  output logic [7:0] FOU_3_LOW
);

`ifdef TR_FUZZY_LOWER_EN
  localparam logic [2:0] LAST_K = 3'd5;
`else
  localparam logic [2:0] LAST_K = 3'd2;
  logic [7:0] low_scaled;
`endif

  state_t      state, state_n;
  region_t     region_c, region_q;
  logic [7:0]  x_reg;
  logic [2:0]  k;
  mf_t         mf;
  logic [15:0] num;
  logic [7:0]  den;
  logic [15:0] quotient;
  logic        div_valid;
  logic [7:0]  grade;
  logic        done_q;
  logic [7:0]  shadow      [6];
  logic [7:0]  shadow_next [6];
  logic [7:0]  fou         [6];

  assign mf = mf_params(k);

  // Plateau wins over the zero check so shoulders reach full height at x=0 / x=255.
  always_comb begin
    region_c = R_ZERO;
    num      = '0;
    den      = 8'd1;
    if (x_reg >= mf.b && x_reg <= mf.c) begin
      region_c = R_PLAT;
    end else if (x_reg <= mf.a || x_reg >= mf.d) begin
      region_c = R_ZERO;
    end else if (x_reg < mf.b) begin
      region_c = R_RISE;
      num      = 16'(mf.h) * 16'(x_reg - mf.a);
      den      = mf.b - mf.a;
    end else begin
      region_c = R_FALL;
      num      = 16'(mf.h) * 16'(mf.d - x_reg);
      den      = mf.d - mf.c;
    end
  end

  tr_fuzzy_div u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (EN_SCLK),
    .load     (state == S_CALC),
    .dividend (num),
    .divisor  (den),
    .quotient (quotient),
    .valid    (div_valid)
  );

  always_comb begin
    case (region_q)
      R_PLAT:  grade = mf.h;
      R_ZERO:  grade = 8'd0;
      default: grade = (|quotient[15:8]) ? 8'hFF : quotient[7:0];
    endcase
  end

`ifndef TR_FUZZY_LOWER_EN
  assign low_scaled = 8'((16'(grade) * 16'(H_LOW)) >> 8);
`endif

  always_comb begin
    shadow_next = shadow;
    if (state == S_WB) begin
      shadow_next[k] = grade;
`ifdef TR_FUZZY_LOWER_EN
`else
      shadow_next[k + 3'd3] = low_scaled;
`endif
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_LOAD;
      S_LOAD:  state_n = S_CALC;
      S_CALC:  state_n = S_DIV;
      S_DIV:   if (div_valid) state_n = S_WB;
      S_WB:    state_n = (k == LAST_K) ? S_DONE : S_CALC;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Results are published on the edge entering DONE so they are visible while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      x_reg    <= '0;
      k        <= '0;
      region_q <= R_ZERO;
      done_q   <= 1'b0;
      shadow   <= '{default: '0};
      fou      <= '{default: '0};
    end else if (EN_SCLK) begin
      state  <= state_n;
      done_q <= (state == S_WB) && (k == LAST_K);
      if (state == S_IDLE && start) x_reg <= x;
      if (state == S_LOAD) k <= '0;
      if (state == S_CALC) region_q <= region_c;
      if (state == S_WB) begin
        shadow <= shadow_next;
        if (k != LAST_K) k <= k + 3'd1;
        else fou <= shadow_next;
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = done_q;
  assign FOU_1_UP  = fou[0];
  assign FOU_2_UP  = fou[1];
  assign FOU_3_UP  = fou[2];
  assign FOU_1_LOW = fou[3];
  assign FOU_2_LOW = fou[4];
  assign FOU_3_LOW = fou[5];

endmodule

// File: tb/tb_tr_fuzzify.sv
// Self-checking bench for tr_fuzzify: cycle-level transaction model plus directed and random conversions.
// Works with TR_FUZZY_LOWER_EN either defined or undefined.
module tb_tr_fuzzify;

`ifdef TR_FUZZY_LOWER_EN
  localparam int LAT = 110;
`else
  localparam int LAT = 56;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en_sclk;
  logic       start;
  logic [7:0] x;
  logic       busy;
  logic       done;
  logic [7:0] fou_1_up, fou_2_up, fou_3_up, fou_1_low, fou_2_low, fou_3_low;

  int checks = 0;
  int errors = 0;

  int bp [6][4] = '{'{0, 0, 64, 128}, '{64, 112, 144, 192}, '{128, 192, 255, 255},
                    '{0, 0, 48, 112}, '{80, 120, 136, 176}, '{144, 208, 255, 255}};

  tr_fuzzify dut (
    .clk       (clk),
    .rst       (rst),
    .EN_SCLK   (en_sclk),
    .start     (start),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .FOU_1_UP  (fou_1_up),
    .FOU_2_UP  (fou_2_up),
    .FOU_3_UP  (fou_3_up),
    .FOU_1_LOW (fou_1_low),
    .FOU_2_LOW (fou_2_low),
    .FOU_3_LOW (fou_3_low)
  );

  initial forever #5 clk = ~clk;

  // Trapezoid grade straight from the region rules.
  function automatic int raw_grade(input int idx, input int xv);
    int a, b, c, d, h, g;
    a = bp[idx][0];
    b = bp[idx][1];
    c = bp[idx][2];
    d = bp[idx][3];
    h = (idx < 3) ? 255 : 204;
    if (xv >= b && xv <= c) g = h;
    else if (xv <= a || xv >= d) g = 0;
    else if (xv < b) g = h * (xv - a) / (b - a);
    else g = h * (d - xv) / (d - c);
    if (g > 255) g = 255;
    return g;
  endfunction

  function automatic int grade_of(input int idx, input int xv);
`ifndef TR_FUZZY_LOWER_EN
    if (idx >= 3) return (raw_grade(idx - 3, xv) * 204) >> 8;
`endif
    return raw_grade(idx, xv);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Transaction model: enabled-cycle index since start acceptance, 0 when idle.
  int  m_cnt = 0;
  int  m_x = 0;
  int  m_out [6];
  bit  m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_live <= 1'b1;
      for (int i = 0; i < 6; i++) m_out[i] <= 0;
    end else if (en_sclk) begin
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= 1;
          m_x   <= int'(x);
        end
      end else if (m_cnt == LAT) begin
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == LAT)
          for (int i = 0; i < 6; i++) m_out[i] <= grade_of(i, m_x);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("busy", int'(busy), int'(m_cnt != 0 && m_cnt != LAT));
      checkOutput("done", int'(done), int'(m_cnt == LAT));
      checkOutput("fou_1_up", int'(fou_1_up), m_out[0]);
      checkOutput("fou_2_up", int'(fou_2_up), m_out[1]);
      checkOutput("fou_3_up", int'(fou_3_up), m_out[2]);
      checkOutput("fou_1_low", int'(fou_1_low), m_out[3]);
      checkOutput("fou_2_low", int'(fou_2_low), m_out[4]);
      checkOutput("fou_3_low", int'(fou_3_low), m_out[5]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // mode 0: always enabled, 1: random enable, 2: enable low for wall cycles 30..36.
  task automatic run_wait(input int mode, input bit inject, output int en_cyc, output int wall);
    en_cyc = 1;
    wall   = 1;
    while (!done && wall < 4 * LAT) begin
      case (mode)
        1:       en_sclk = ($urandom_range(0, 3) != 0);
        2:       en_sclk = !(wall >= 30 && wall < 37);
        default: en_sclk = 1'b1;
      endcase
      start = inject && (wall == 20);
      x     = 8'($urandom);
      tick();
      wall++;
      if (en_sclk) en_cyc++;
    end
    start   = 1'b0;
    en_sclk = 1'b1;
    checkOutput("done_within_bound", int'(done), 1);
  endtask

  // One full conversion; leaves the DUT idle afterwards.
  task automatic applyStimulus(input int xv, input int mode, input bit inject,
                               output int en_cyc, output int wall);
    en_sclk = 1'b1;
    x       = 8'(xv);
    start   = 1'b1;
    tick();
    start = 1'b0;
    run_wait(mode, inject, en_cyc, wall);
    tick();
  endtask

  int en_cyc, wall, n_done;
  int dir_x [8] = '{0, 96, 128, 255, 64, 112, 48, 200};

  initial begin
    rst     = 1'b1;
    en_sclk = 1'b1;
    start   = 1'b0;
    x       = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_fou_2_up", int'(fou_2_up), 0);
    checkOutput("reset_fou_3_low", int'(fou_3_low), 0);

    checkOutput("model_96_1u", grade_of(0, 96), 127);
    checkOutput("model_96_2u", grade_of(1, 96), 170);
    checkOutput("model_0_1u", grade_of(0, 0), 255);
    checkOutput("model_255_3u", grade_of(2, 255), 255);
`ifdef TR_FUZZY_LOWER_EN
    checkOutput("model_96_1l", grade_of(3, 96), 51);
    checkOutput("model_96_2l", grade_of(4, 96), 81);
    checkOutput("model_128_2l", grade_of(4, 128), 204);
`else
    checkOutput("model_96_1l", grade_of(3, 96), 101);
    checkOutput("model_96_2l", grade_of(4, 96), 135);
    checkOutput("model_128_2l", grade_of(4, 128), 203);
`endif

    foreach (dir_x[i]) begin
      applyStimulus(dir_x[i], 0, 1'b0, en_cyc, wall);
      checkOutput("latency", en_cyc, LAT);
      if (dir_x[i] == 96) begin
        checkOutput("x96_fou_1_up", int'(fou_1_up), 127);
        checkOutput("x96_fou_2_up", int'(fou_2_up), 170);
        checkOutput("x96_fou_3_up", int'(fou_3_up), 0);
`ifdef TR_FUZZY_LOWER_EN
        checkOutput("x96_fou_1_low", int'(fou_1_low), 51);
        checkOutput("x96_fou_2_low", int'(fou_2_low), 81);
`else
        checkOutput("x96_fou_1_low", int'(fou_1_low), 101);
        checkOutput("x96_fou_2_low", int'(fou_2_low), 135);
`endif
      end
      if (dir_x[i] == 0) begin
        checkOutput("x0_fou_1_up", int'(fou_1_up), 255);
        checkOutput("x0_fou_2_up", int'(fou_2_up), 0);
      end
      if (dir_x[i] == 128) begin
        checkOutput("x128_fou_2_up", int'(fou_2_up), 255);
`ifdef TR_FUZZY_LOWER_EN
        checkOutput("x128_fou_2_low", int'(fou_2_low), 204);
`else
        checkOutput("x128_fou_2_low", int'(fou_2_low), 203);
`endif
      end
    end

    applyStimulus(96, 2, 1'b0, en_cyc, wall);
    checkOutput("hold_latency_enabled", en_cyc, LAT);
    checkOutput("hold_latency_wall", wall, LAT + 7);
    checkOutput("hold_fou_2_up", int'(fou_2_up), 170);

    applyStimulus(96, 0, 1'b1, en_cyc, wall);
    checkOutput("restart_latency", en_cyc, LAT);
    n_done = 0;
    repeat (LAT + 5) begin
      tick();
      if (done) n_done++;
    end
    checkOutput("no_extra_done", n_done, 0);

    x     = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_fou_1_up", int'(fou_1_up), 0);
    checkOutput("midrst_fou_2_up", int'(fou_2_up), 0);
    repeat (3) tick();
    applyStimulus(160, 0, 1'b0, en_cyc, wall);
    checkOutput("post_rst_latency", en_cyc, LAT);

    repeat (15) begin
      repeat ($urandom_range(0, 3)) begin
        en_sclk = 1'($urandom_range(0, 1));
        x       = 8'($urandom);
        tick();
      end
      applyStimulus(int'($urandom_range(0, 255)), 1, 1'($urandom_range(0, 1)), en_cyc, wall);
      checkOutput("rand_latency", en_cyc, LAT);
    end

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
